// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: TXDATA pushes into a byte FIFO, STATUS reports fill/overflow,
// and a small FSM shifts bytes out LSB first with a fixed number of clocks per bit.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic [2:0]  mem_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        tx,
    output logic        irq_empty
);

    // state    | meaning
    // ST_IDLE  | line high; pops the FIFO head when count>0
    // ST_START | start bit (0) for CLKS_PER_BIT clocks
    // ST_DATA  | eight data bits, LSB first, shreg shifts right per bit
    // ST_STOP  | stop bit (1) for CLKS_PER_BIT clocks
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_TOP = BW'(CLKS_PER_BIT - 1);

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    fifo_q [FIFO_DEPTH];

    logic        push, clr, push_ok, pop;
    logic        full, empty, busy;
    logic [31:0] status_word, sel_word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        unused_wdata;

    assign unused_wdata = ^wdata[31:8];

    assign hit   = (addr[31:3] == BASE_ADDR[31:3]);
    assign push  = mem_we & hit & ~addr[2];
    assign clr   = mem_we & hit & addr[2];
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign busy  = (state_q != ST_IDLE);
    // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot for a push.
    assign push_ok = push & ~full;
    assign pop     = (state_q == ST_IDLE) & ~empty;

    assign irq_empty   = empty & ~busy;
    assign status_word = {16'h0, 8'(count_q), 4'h0, overflow_q, busy, empty, full};

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (push & full) begin
            overflow_d = 1'b1;
        end else if (clr & wdata[3]) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx      = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    shreg_d = fifo_q[rd_ptr_q];
                    baud_d  = BAUD_TOP;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx = 1'b0;
                if (baud_q == '0) begin
                    baud_d  = BAUD_TOP;
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            ST_DATA: begin
                tx = shreg_q[0];
                if (baud_q == '0) begin
                    baud_d  = BAUD_TOP;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            ST_STOP: begin
                if (baud_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Loads see the selected word narrowed by mem_type; TXDATA always reads as zero.
    always_comb begin
        sel_word = addr[2] ? status_word : 32'h0;
        sel_byte = sel_word[{addr[1:0], 3'b000} +: 8];
        sel_half = sel_word[{addr[1], 4'b0000} +: 16];
        rdata    = 32'h0;
        if (hit) begin
            unique case (mem_type)
                3'b000:  rdata = {{24{sel_byte[7]}}, sel_byte};
                3'b001:  rdata = {{16{sel_half[15]}}, sel_half};
                3'b100:  rdata = {24'h0, sel_byte};
                3'b101:  rdata = {16'h0, sel_half};
                default: rdata = sel_word;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            shreg_q    <= 8'h0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level model checked every cycle, a serial decoder, and directed cases.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 8;
    localparam int          C     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_we = 1'b0;
    logic [2:0]  mem_type = 3'b010;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        hit;
    logic        tx;
    logic        irq_empty;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model: byte queue plus the frame currently on the line and how many clocks of it have elapsed.
    bit [7:0] mq[$];
    bit       m_ovf = 1'b0;
    bit       m_act = 1'b0;
    int       m_t   = 0;
    int       m_n0  = 0;
    bit [7:0] m_byte = 8'h0;

    bit       dec_on = 1'b0;
    int       dec_k  = 0;
    bit [7:0] dec_sh = 8'h0;
    bit [7:0] rx_q[$];

    mmio_uart_tx dut (
        .clk       (clk),
        .rst       (rst),
        .mem_we    (mem_we),
        .mem_type  (mem_type),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .hit       (hit),
        .tx        (tx),
        .irq_empty (irq_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit frame_bit(input bit [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a, input logic [2:0] mt);
        logic [31:0] w;
        logic [7:0]  by;
        logic [15:0] hw;
        if (a[31:3] != BASE[31:3]) return 32'h0;
        w = 32'h0;
        if (a[2]) begin
            w = 32'(mq.size()) * 32'd256 + (m_ovf ? 32'd8 : 32'd0) + (m_act ? 32'd4 : 32'd0)
              + (mq.size() == 0 ? 32'd2 : 32'd0) + (mq.size() == DEPTH ? 32'd1 : 32'd0);
        end
        by = 8'(w >> (32'd8 * 32'(a[1:0])));
        hw = 16'(w >> (32'd16 * 32'(a[1])));
        case (mt)
            3'b000:  return {{24{by[7]}}, by};
            3'b001:  return {{16{hw[15]}}, hw};
            3'b100:  return {24'h0, by};
            3'b101:  return {16'h0, hw};
            default: return w;
        endcase
    endfunction

    task automatic model_step();
        bit is_hit;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_act = 1'b0;
            m_t   = 0;
            return;
        end
        is_hit = (addr[31:3] == BASE[31:3]);
        m_n0 = mq.size();
        if (m_act) begin
            m_t++;
            if (m_t == 10 * C) m_act = 1'b0;
        end else if (m_n0 > 0) begin
            m_byte = mq.pop_front();
            m_act  = 1'b1;
            m_t    = 0;
        end
        if (mem_we && is_hit && !addr[2]) begin
            if (m_n0 < DEPTH) mq.push_back(wdata[7:0]);
            else m_ovf = 1'b1;
        end
        if (mem_we && is_hit && addr[2] && wdata[3]) m_ovf = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("tx", 32'(tx), 32'(m_act ? frame_bit(m_byte, m_t / C) : 1'b1));
            check("irq_empty", 32'(irq_empty), 32'(mq.size() == 0 && !m_act));
            check("hit", 32'(hit), 32'(addr[31:3] == BASE[31:3]));
            if (!mem_we) check("rdata", rdata, exp_rd(addr, mem_type));
        end
    end

    // Independent line decoder: samples mid-bit after seeing a start bit.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            dec_on = 1'b0;
        end else if (!dec_on) begin
            if (tx === 1'b0) begin
                dec_on = 1'b1;
                dec_k  = 0;
            end
        end else begin
            dec_k++;
            if (dec_k > C && dec_k < 9 * C && dec_k % C == C / 2) dec_sh[dec_k / C - 1] = tx;
            if (dec_k == 9 * C + C / 2) begin
                rx_q.push_back(dec_sh);
                dec_on = 1'b0;
            end
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] mt);
        addr = a;
        wdata = d;
        mem_type = mt;
        mem_we = 1'b1;
        @(posedge clk);
        #1;
        mem_we = 1'b0;
    endtask

    task automatic do_read(input string nm, input logic [31:0] a, input logic [2:0] mt,
                           input logic [31:0] exp);
        addr = a;
        mem_type = mt;
        mem_we = 1'b0;
        @(negedge clk);
        check(nm, rdata, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max);
        int k;
        k = 0;
        while (irq_empty !== 1'b1 && k < max) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (irq_empty !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL wait_idle timeout irq_empty=%b required=1", irq_empty);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [9:0] f1;
        bit   [7:0] exp5[20];
        bit   [7:0] e;

        @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_tx", 32'(tx), 32'h1);
        check("rst_irq", 32'(irq_empty), 32'h1);
        @(posedge clk);
        #1;
        do_read("rst_status", BASE + 32'd4, 3'b010, 32'h0000_0002);

        // Case 1: single 0x55 frame, exact waveform
        rx_q.delete();
        f1 = 10'b1010101010;
        do_store(BASE, 32'h0000_0055, 3'b010);
        addr = BASE + 32'd4;
        for (int n = 0; n <= 41; n++) begin
            @(negedge clk);
            if (n == 0 || n == 41) check("t1_tx_idle", 32'(tx), 32'h1);
            else check("t1_tx_frame", 32'(tx), 32'(f1[(n - 1) / C]));
            if (n == 40) check("t1_irq_stop", 32'(irq_empty), 32'h0);
            if (n == 41) check("t1_irq_done", 32'(irq_empty), 32'h1);
        end
        @(posedge clk);
        #1;
        check("t1_rx_cnt", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("t1_rx_byte", 32'(rx_q[0]), 32'h55);

        // Case 2/3: fill past depth, overflow, clear
        rx_q.delete();
        for (int i = 0; i < 9; i++) do_store(BASE, 32'h10 + 32'(i), 3'b000);
        do_read("t2_status9", BASE + 32'd4, 3'b010, 32'h0000_0805);
        do_store(BASE, 32'hEE, 3'b000);
        do_read("t2_status10", BASE + 32'd4, 3'b010, 32'h0000_080D);
        do_store(BASE + 32'd4, 32'h7, 3'b010);
        do_read("t3_noclr", BASE + 32'd4, 3'b010, 32'h0000_080D);
        do_store(BASE + 32'd4, 32'h8, 3'b010);
        do_read("t3_clr", BASE + 32'd4, 3'b010, 32'h0000_0805);
        wait_idle(600);
        check("t2_rx_cnt", 32'(rx_q.size()), 32'd9);
        for (int i = 0; i < 9 && i < rx_q.size(); i++) check("t2_rx_byte", 32'(rx_q[i]), 32'h10 + 32'(i));

        // Case 4: reset in the middle of a frame
        rx_q.delete();
        do_store(BASE, 32'hA1, 3'b010);
        do_store(BASE, 32'hA2, 3'b010);
        do_store(BASE, 32'hA3, 3'b010);
        repeat (5) @(posedge clk);
        #1;
        addr = BASE + 32'd4;
        mem_type = 3'b010;
        @(negedge clk);
        check("t4_busy_pre", rdata, 32'h0000_0204);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t4_rst_tx", 32'(tx), 32'h1);
        check("t4_rst_irq", 32'(irq_empty), 32'h1);
        check("t4_rst_status", rdata, 32'h0000_0002);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("t4_no_frames", 32'(rx_q.size()), 32'd0);
        check("t4_tx_high", 32'(tx), 32'h1);

        // Case 5: 20 bytes in bursts of 4, pointers wrap
        rx_q.delete();
        for (int i = 0; i < 20; i++) begin
            e = 8'((i * 37 + 5) & 255);
            exp5[i] = e;
        end
        for (int b = 0; b < 5; b++) begin
            wait_idle(300);
            for (int j = 0; j < 4; j++) do_store(BASE, 32'(exp5[b * 4 + j]), 3'b000);
        end
        wait_idle(300);
        check("t5_rx_cnt", 32'(rx_q.size()), 32'd20);
        for (int i = 0; i < 20 && i < rx_q.size(); i++) check("t5_rx_byte", 32'(rx_q[i]), 32'(exp5[i]));

        // Case 6: out-of-window store and sub-word loads
        addr = BASE + 32'd8;
        wdata = 32'h77;
        mem_type = 3'b010;
        mem_we = 1'b1;
        @(negedge clk);
        check("t6_hit_miss", 32'(hit), 32'h0);
        @(posedge clk);
        #1;
        mem_we = 1'b0;
        do_read("t6_no_push", BASE + 32'd4, 3'b010, 32'h0000_0002);
        do_read("t6_miss_rd", BASE + 32'd12, 3'b010, 32'h0);
        do_store(BASE, 32'hC1, 3'b000);
        do_store(BASE, 32'hC2, 3'b000);
        do_store(BASE, 32'hC3, 3'b000);
        do_read("t6_lb_cnt", BASE + 32'd5, 3'b000, 32'h0000_0002);
        do_read("t6_lh", BASE + 32'd4, 3'b001, 32'h0000_0204);
        do_read("t6_lbu", BASE + 32'd4, 3'b100, 32'h0000_0004);
        do_read("t6_txdata", BASE, 3'b010, 32'h0);
        wait_idle(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
